ct_had_pcfifo_ctrl: RTL

Control block for the HAD PC trace FIFO. It generates the FIFO write enable from the debug enable, debug-mode and freeze state. It sequences debugger reads of the PCFIFO register so that every read is serialised after in-flight writes and ends with a one-cycle acknowledge. It also keeps a saturating occupancy count so software can tell valid entries from reads of an empty FIFO. It sits between the HAD register file and the PC FIFO datapath inside the HAD.

---
 rtl/ct_had_pcfifo_ctrl_pkg.sv | 13 +
 rtl/ct_had_pcfifo_ctrl_if.sv | 51 +++++
 rtl/ct_had_pcfifo_popc.sv | 9 +
 rtl/ct_had_pcfifo_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/ct_had_pcfifo_ctrl_pkg.sv
// Shared constants for the HAD PC trace FIFO control block: depth, counter
// width and read-sequencer state encodings.
package ct_had_pcfifo_ctrl_pkg;

  localparam int PCFIFO_DEPTH = 16;
  localparam int PCFIFO_CNT_W = 5;

  localparam logic [1:0] RD_IDLE  = 2'b00;
  localparam logic [1:0] RD_DRAIN = 2'b01;
  localparam logic [1:0] RD_READ  = 2'b10;
  localparam logic [1:0] RD_ACK   = 2'b11;

endpackage

// File: rtl/ct_had_pcfifo_ctrl_if.sv
// Signal bundle between the HAD register file and the PC FIFO control block.
// The trigger signals exist only when HAD_PCFIFO_TRIG_EN is defined.
interface ct_had_pcfifo_ctrl_if #(parameter int CNT_W = 5);

  // Read handshake: regs_pcfifo_rd_req is a one-cycle request, taken only
  // while the sequencer is idle (otherwise dropped). Each taken request ends
  // in exactly one pcfifo_rd_ack pulse; pcfifo_rd_empty is meaningful only
  // in that ack cycle.
  logic             regs_pcfifo_en;
  logic             had_dbg_mode;
  logic [3:0]       rtu_had_xx_pcfifo_chgflow;
  logic             regs_pcfifo_rd_req;
  logic             ctrl_pcfifo_wen;
  logic             ctrl_pcfifo_ren;
  logic             pcfifo_rd_ack;
  logic             pcfifo_rd_empty;
  logic [CNT_W-1:0] pcfifo_cnt;
  logic [1:0]       rd_state;
`ifdef HAD_PCFIFO_TRIG_EN
  logic             had_trig_hit;
  logic [3:0]       regs_pcfifo_post_cnt;
  logic             pcfifo_frozen;

  modport master (
    output regs_pcfifo_en, had_dbg_mode, rtu_had_xx_pcfifo_chgflow,
           regs_pcfifo_rd_req, had_trig_hit, regs_pcfifo_post_cnt,
    input  ctrl_pcfifo_wen, ctrl_pcfifo_ren, pcfifo_rd_ack, pcfifo_rd_empty,
           pcfifo_cnt, rd_state, pcfifo_frozen
  );
  modport slave (
    input  regs_pcfifo_en, had_dbg_mode, rtu_had_xx_pcfifo_chgflow,
           regs_pcfifo_rd_req, had_trig_hit, regs_pcfifo_post_cnt,
    output ctrl_pcfifo_wen, ctrl_pcfifo_ren, pcfifo_rd_ack, pcfifo_rd_empty,
           pcfifo_cnt, rd_state, pcfifo_frozen
  );
`else
  modport master (
    output regs_pcfifo_en, had_dbg_mode, rtu_had_xx_pcfifo_chgflow,
           regs_pcfifo_rd_req,
    input  ctrl_pcfifo_wen, ctrl_pcfifo_ren, pcfifo_rd_ack, pcfifo_rd_empty,
           pcfifo_cnt, rd_state
  );
  modport slave (
    input  regs_pcfifo_en, had_dbg_mode, rtu_had_xx_pcfifo_chgflow,
           regs_pcfifo_rd_req,
    output ctrl_pcfifo_wen, ctrl_pcfifo_ren, pcfifo_rd_ack, pcfifo_rd_empty,
           pcfifo_cnt, rd_state
  );
`endif

endinterface

// File: rtl/ct_had_pcfifo_popc.sv
// 4-bit population count of retire-lane strobes.
module ct_had_pcfifo_popc (
  input  logic [3:0] din,
  output logic [2:0] cnt
);

  assign cnt = 3'(din[0]) + 3'(din[1]) + 3'(din[2]) + 3'(din[3]);

endmodule

// File: rtl/ct_had_pcfifo_ctrl.sv
// PC trace FIFO control: write enable, serialised debugger read sequencer and
// saturating occupancy count. Optional trigger freeze under HAD_PCFIFO_TRIG_EN.
module ct_had_pcfifo_ctrl
  import ct_had_pcfifo_ctrl_pkg::*;
#(
  parameter int DEPTH = PCFIFO_DEPTH,
  parameter int CNT_W = PCFIFO_CNT_W
) (
  input  logic                 cpuclk,
  input  logic                 cpurst_b,
  ct_had_pcfifo_ctrl_if.slave  bus
);

  logic             wen;
  logic             frozen;
  logic [2:0]       n;
  logic [2:0]       n_d;
  logic             dec;
  logic [CNT_W:0]   cnt_sum;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [1:0]       state;
  logic [1:0]       state_next;
  logic             empty_q;

  assign wen = bus.regs_pcfifo_en & ~bus.had_dbg_mode & ~frozen;

  ct_had_pcfifo_popc u_popc_wr (
    .din (bus.rtu_had_xx_pcfifo_chgflow & {4{wen}}),
    .cnt (n)
  );

  // Lanes accepted now are committed by the FIFO one cycle later.
  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) n_d <= 3'd0;
    else           n_d <= n;
  end

  assign dec     = (state == RD_READ) && (cnt != '0);
  assign cnt_sum = {1'b0, cnt} - (CNT_W+1)'(dec) + (CNT_W+1)'(n_d);

  always_comb begin
    cnt_next = cnt_sum[CNT_W-1:0];
    if (cnt_sum > (CNT_W+1)'(DEPTH)) cnt_next = CNT_W'(DEPTH);
  end

  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) cnt <= '0;
    else           cnt <= cnt_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RD_IDLE:  if (bus.regs_pcfifo_rd_req) state_next = RD_DRAIN;
      RD_DRAIN: if ((n_d == 3'd0) && (n == 3'd0)) state_next = RD_READ;
      RD_READ:  state_next = RD_ACK;
      default:  state_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state   <= RD_IDLE;
      empty_q <= 1'b0;
    end else begin
      state <= state_next;
      if (state == RD_READ) empty_q <= (cnt == '0);
    end
  end

`ifdef HAD_PCFIFO_TRIG_EN
  logic       armed;
  logic       frozen_q;
  logic       dbg_d;
  logic       trig_clear;
  logic [2:0] n_post;
  logic [3:0] post_left;
  logic [3:0] post_left_next;

  ct_had_pcfifo_popc u_popc_post (
    .din (bus.rtu_had_xx_pcfifo_chgflow & {4{wen & armed}}),
    .cnt (n_post)
  );

  assign trig_clear     = ~bus.regs_pcfifo_en | (dbg_d & ~bus.had_dbg_mode);
  assign post_left_next = (post_left > {1'b0, n_post}) ? (post_left - {1'b0, n_post}) : 4'd0;

  // The crossing cycle still records its lanes; freeze takes effect next cycle.
  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      armed     <= 1'b0;
      frozen_q  <= 1'b0;
      dbg_d     <= 1'b0;
      post_left <= 4'd0;
    end else begin
      dbg_d <= bus.had_dbg_mode;
      if (trig_clear) begin
        armed    <= 1'b0;
        frozen_q <= 1'b0;
      end else if (bus.had_trig_hit && wen && !armed) begin
        armed     <= 1'b1;
        post_left <= bus.regs_pcfifo_post_cnt;
        frozen_q  <= (bus.regs_pcfifo_post_cnt == 4'd0);
      end else if (armed) begin
        post_left <= post_left_next;
        if (post_left_next == 4'd0) frozen_q <= 1'b1;
      end
    end
  end

  assign frozen            = frozen_q;
  assign bus.pcfifo_frozen = frozen_q;
`else
  assign frozen = 1'b0;
`endif

  assign bus.ctrl_pcfifo_wen = wen;
  assign bus.ctrl_pcfifo_ren = (state == RD_READ);
  assign bus.pcfifo_rd_ack   = (state == RD_ACK);
  assign bus.pcfifo_rd_empty = (state == RD_ACK) & empty_q;
  assign bus.pcfifo_cnt      = cnt;
  assign bus.rd_state        = state;

endmodule
